// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Board-side responder for a 32-bit LSB-first SPI link. The SPI pins are
// oversampled on BOARD_CLOCK. A normal frame delivers a write word to local
// logic. A frame whose low nibble equals READ_CMD is a read command. The word
// for that read is shifted back on MISO during the next chip-select frame.
//
// Ports
//   BOARD_CLOCK  in   sole clock, all logic on the rising edge
//   RST          in   asynchronous active-high reset
//   SPI_CLK      in   SPI clock from the master, idle low
//   SPI_CS_N     in   chip select, active low
//   SPI_MOSI     in   serial data from the master
//   SPI_MISO     out  serial data to the master
//   SPI_MISO_OE  out  MISO pad drive enable
//   RX_DATA_O    out  last complete write word
//   RX_VALID_O   out  one-cycle pulse when RX_DATA_O updates
//   RD_REQ_O     out  one-cycle pulse when a read command arrives
//   RD_CMD_O     out  full read-command word, held until the next command
//   TX_DATA_I    in   read-response word, sampled when the response frame starts
//   FRAME_ERR_O  out  one-cycle pulse when a frame ends with an illegal bit count
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int         SYNC_STAGES = 2,        // must be >= 2
    parameter int         WORD_BITS   = 32,       // must fit the 6-bit counter
    parameter logic [3:0] READ_CMD    = 4'b1110
) (
    input  logic                 BOARD_CLOCK,
    input  logic                 RST,
    input  logic                 SPI_CLK,
    input  logic                 SPI_CS_N,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic                 SPI_MISO_OE,
    output logic [WORD_BITS-1:0] RX_DATA_O,
    output logic                 RX_VALID_O,
    output logic                 RD_REQ_O,
    output logic [WORD_BITS-1:0] RD_CMD_O,
    input  logic [WORD_BITS-1:0] TX_DATA_I,
    output logic                 FRAME_ERR_O
);

    localparam int         CNT_W    = 6;
    localparam logic [5:0] CNT_FULL = 6'(WORD_BITS);
    localparam logic [5:0] CNT_LAST = 6'(WORD_BITS - 1);
    localparam logic [5:0] CNT_MAX  = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT_RD,
        ST_SEND
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizers, edge-detect history flops and flush tracking
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;
    // Fills with ones after reset. The top bit is set once the history flops
    // hold real pin samples rather than reset values.
    logic [SYNC_STAGES:0]   flush_q;

    // NOTE: the synchronizers are reset to the idle pin levels (CS_N high,
    // SCLK low). An idle bus then produces no edge when reset is released.
    always_ff @(posedge BOARD_CLOCK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            flush_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Each stage
            // therefore takes the value its neighbour had before this edge.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
            flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sync_valid;
    logic cs_fall;
    logic cs_rise;
    logic bit_fall;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sync_valid = flush_q[SYNC_STAGES];

    // If CS_N is held low through reset, the preset-high history flop would
    // otherwise show a phantom falling edge. A frame may only start after the
    // chain has been flushed with real pin samples.
    assign cs_fall  = sync_valid & cs_hist_q & ~cs_s;
    assign cs_rise  = ~cs_hist_q & cs_s;
    // SCLK activity counts only while the chip is selected.
    assign bit_fall = sclk_hist_q & ~sclk_s & ~cs_s;

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     bit_cnt_d;
    logic [WORD_BITS-1:0] rx_shift_q;
    logic [WORD_BITS-1:0] rx_shift_d;
    logic [WORD_BITS-1:0] tx_shift_q;
    logic [WORD_BITS-1:0] tx_shift_d;
    logic                 frame_full;
    logic                 send_len_ok;

    // The counter saturates, so a long runaway frame cannot wrap around to a
    // legal length.
    assign bit_cnt_d   = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 6'd1;
    // LSB-first: each new bit enters at the top and moves down one place
    // per clock.
    assign rx_shift_d  = {mosi_s, rx_shift_q[WORD_BITS-1:1]};
    assign tx_shift_d  = {1'b0, tx_shift_q[WORD_BITS-1:1]};
    assign frame_full  = (bit_cnt_q == CNT_FULL);
    // Bit 0 of the response is already on MISO when CS falls. A master that
    // stops after its last sampling edge has therefore made only
    // WORD_BITS-1 falls.
    assign send_len_ok = frame_full || (bit_cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Frame FSM with registered outputs
    // -------------------------------------------------------------------------
    state_t               state_q;
    logic [WORD_BITS-1:0] rx_data_q;
    logic [WORD_BITS-1:0] rd_cmd_q;
    logic                 rx_valid_q;
    logic                 rd_req_q;
    logic                 frame_err_q;
    logic                 miso_oe_q;

    always_ff @(posedge BOARD_CLOCK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rd_cmd_q    <= '0;
            rx_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt_q  <= '0;
                        rx_shift_q <= '0;
                        state_q    <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    // A CS rise in the same cycle as an SCLK fall ends the
                    // frame, and that last bit is not counted.
                    if (cs_rise) begin
                        if (frame_full && rx_shift_q[3:0] == READ_CMD) begin
                            rd_cmd_q <= rx_shift_q;
                            rd_req_q <= 1'b1;
                            state_q  <= ST_WAIT_RD;
                        end else if (frame_full) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (bit_fall) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_d;
                    end
                end

                ST_WAIT_RD: begin
                    // Waits without a timeout for the response frame.
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        tx_shift_q <= TX_DATA_I;
                        miso_oe_q  <= 1'b1;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (cs_rise) begin
                        miso_oe_q   <= 1'b0;
                        tx_shift_q  <= '0;
                        frame_err_q <= ~send_len_ok;
                        state_q     <= ST_IDLE;
                    end else if (bit_fall) begin
                        tx_shift_q <= tx_shift_d;
                        bit_cnt_q  <= bit_cnt_d;
                    end
                end

                default: begin
                    miso_oe_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // MISO comes directly from the shifter's low bit, so it is a registered
    // output. It returns to 0 when the response frame ends.
    assign SPI_MISO    = tx_shift_q[0];
    assign SPI_MISO_OE = miso_oe_q;
    assign RX_DATA_O   = rx_data_q;
    assign RX_VALID_O  = rx_valid_q;
    assign RD_REQ_O    = rd_req_q;
    assign RD_CMD_O    = rd_cmd_q;
    assign FRAME_ERR_O = frame_err_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

Board-side SPI responder that terminates the 32-bit LSB-first SPI link driven by the PCI-side SPI master. It oversamples the SPI pins on the board clock, delivers received write words to local logic, and answers read commands by shifting a 32-bit word back on MISO during a second chip-select frame. One instance sits behind each chip-select line.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flops in each input synchronizer (SPI_CLK, SPI_CS_N, SPI_MOSI)
- WORD_BITS, 32, bits per frame
- READ_CMD, 4'b1110, value of received bits [3:0] that marks a read command

Ports:
- BOARD_CLOCK  in  1  sole clock; all logic on its rising edge
- RST  in  1  asynchronous, active-high reset
- SPI_CLK  in  1  SPI clock from master, idle low
- SPI_CS_N  in  1  chip select, active low
- SPI_MOSI  in  1  serial data from master
- SPI_MISO  out  1  serial data to master
- SPI_MISO_OE  out  1  MISO drive enable (pad tri-state control)
- RX_DATA_O  out  WORD_BITS  last complete write word
- RX_VALID_O  out  1  one-cycle pulse, RX_DATA_O updated
- RD_REQ_O  out  1  one-cycle pulse, read command received
- RD_CMD_O  out  WORD_BITS  full read-command word, valid from RD_REQ_O until next frame
- TX_DATA_I  in  WORD_BITS  read-response word, sampled at start of response frame
- FRAME_ERR_O  out  1  one-cycle pulse, frame ended with bit count ≠ WORD_BITS

## Operation
- Inputs pass through SYNC_STAGES flops, plus one history flop per signal for edge detection. Edges are evaluated only on synchronized values.
- Bit order is LSB-first. The master changes MOSI on SPI_CLK rising edges and samples MISO on rising edges. This block samples MOSI on detected SPI_CLK falling edges and updates MISO on falling edges.
- 6-bit bit counter saturates at 63.
- States:
  - IDLE: MISO_OE=0. A CS_N falling edge goes to RECV and clears the counter and the shift register.
  - RECV: on each SCLK fall, shift right with MOSI entering bit WORD_BITS-1, and increment the counter. On CS_N rise:
    - count==WORD_BITS and shift[3:0]==READ_CMD: load RD_CMD_O, pulse RD_REQ_O, go to WAIT_RD.
    - count==WORD_BITS, other command: load RX_DATA_O, pulse RX_VALID_O, go to IDLE.
    - otherwise: pulse FRAME_ERR_O, go to IDLE, leave RX_DATA_O unchanged.
  - WAIT_RD: MISO_OE=0. SCLK edges are ignored. A CS_N fall latches TX_DATA_I into the tx shifter, drives SPI_MISO=TX_DATA_I[0], sets MISO_OE=1, clears the counter, and goes to SEND. There is no timeout.
  - SEND: MOSI is ignored. On each SCLK fall, shift tx right, drive the new bit 0 (zero fill), and increment the counter. On CS_N rise: MISO_OE=0, go to IDLE, and pulse FRAME_ERR_O if count ≠ WORD_BITS-1 or WORD_BITS. The master's first response bit is already on MISO at CS fall, so up to WORD_BITS-1 falls are legal.
- SCLK edges while the synchronized CS_N is high are ignored in every state.
- If a CS_N rise and an SCLK fall are detected in the same cycle, the CS_N rise wins and the bit is not counted.
- If CS_N is low when reset releases, the block stays in IDLE until a CS_N high→low edge is seen.

## Timing
- Reset values:
  - SPI_MISO=0, SPI_MISO_OE=0
  - RX_DATA_O=0, RD_CMD_O=0
  - RX_VALID_O=0, RD_REQ_O=0, FRAME_ERR_O=0
  - state IDLE, synchronizers all high except SPI_CLK/MOSI low
- Reset asserted mid-frame aborts immediately with no pulse. The block then obeys the CS-low-at-release rule above.
- Pin-to-detect latency is SYNC_STAGES+1 BOARD_CLOCK cycles. RX_VALID_O, RD_REQ_O and FRAME_ERR_O assert SYNC_STAGES+1 cycles after the CS_N pin rise.
- MISO updates SYNC_STAGES+1 cycles after the SCLK pin fall. This must be shorter than the SCLK half period, which is 4 BOARD_CLOCK cycles with the master's divide-by-8. The default of 2 therefore meets it, and SYNC_STAGES ≥3 is unsupported at that rate.
- The CS_N high gap between frames must be at least 1 synchronized cycle. Back-to-back write frames need no dead time beyond that.
- TX_DATA_I must be stable from RD_REQ_O+1 until SYNC_STAGES+1 cycles after the response-frame CS_N fall.

## Test plan
- Write frame, 32 bits of 0xA5A50003 → RX_DATA_O=0xA5A50003, exactly one RX_VALID_O pulse, RD_REQ_O and FRAME_ERR_O stay 0.
- Read sequence:
  - Stimulus: command 0x0000001E; TX_DATA_I=0xDEADBEEF driven on RD_REQ_O; 2-SCLK CS high gap; 32-clock response frame.
  - Required response: RD_CMD_O=0x0000001E, one RD_REQ_O pulse, master-side capture=0xDEADBEEF, MISO_OE high only while CS low, no FRAME_ERR_O.
- Short frame of 16 bits → one FRAME_ERR_O pulse, RX_DATA_O keeps its previous value, state back to IDLE, next 32-bit write accepted.
- RST asserted after 10 bits of a write → all outputs 0 within the reset cycle. CS still low at release → no pulses. A following full frame of 0x12345678 is received correctly.
- Two back-to-back writes, 0x11111111 then 0x22222222, with 1-SCLK gap → two RX_VALID_O pulses, data in order.
- SCLK toggling while CS_N high, 8 edges, then a valid write of 0x0F0F0F0F → RX_DATA_O=0x0F0F0F0F with no error.
